// File: rtl/booth_mul_arbiter_pkg.sv
// Shared types and defaults for the two-requester Booth multiplier arbiter.
package booth_mul_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_TIMEOUT = 40;

endpackage

// File: rtl/booth_mul_arbiter_rr_arb2.sv
// Two-way round-robin grant: sole requester wins, pointer breaks ties.
module rr_arb2 (
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_ptr,
  output logic o_grant,
  output logic o_gvalid
);

  assign o_gvalid = i_valid0 | i_valid1;
  assign o_grant  = (i_valid0 & i_valid1) ? i_ptr : i_valid1;

endmodule

// File: rtl/booth_mul_arbiter.sv
// Arbitrates two requesters onto one shared Booth multiplier,
// with a completion timeout and a held response channel.
module booth_mul_arbiter
  import booth_mul_arbiter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  input  logic [WIDTH-1:0]   req0_m,
  input  logic [WIDTH-1:0]   req0_q,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [WIDTH-1:0]   req1_m,
  input  logic [WIDTH-1:0]   req1_q,
  output logic               req1_ready,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_m,
  output logic [WIDTH-1:0]   mul_q,
  output logic               mul_rst,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_product,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic               rsp_err,
  output logic [2*WIDTH-1:0] rsp_product
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  // Firing one count early puts rsp_valid exactly TIMEOUT cycles after start
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 2);

  state_t             r_state;
  state_t             w_next;
  logic               r_ptr;
  logic [TW-1:0]      r_timer;
  logic [WIDTH-1:0]   r_m;
  logic [WIDTH-1:0]   r_q;
  logic               r_id;
  logic               r_err;
  logic [2*WIDTH-1:0] r_prod;

  logic w_grant;
  logic w_gvalid;
  logic w_accept;
  logic w_timeout;

  rr_arb2 u_arb (
    .i_valid0 (req0_valid),
    .i_valid1 (req1_valid),
    .i_ptr    (r_ptr),
    .o_grant  (w_grant),
    .o_gvalid (w_gvalid)
  );

  assign w_accept  = !rst && (r_state == IDLE) && w_gvalid;
  assign w_timeout = (r_state == WAIT) && (r_timer == TLAST) && !mul_done;

  assign req0_ready  = w_accept && !w_grant;
  assign req1_ready  = w_accept && w_grant;
  assign mul_start   = (r_state == ISSUE);
  assign mul_m       = r_m;
  assign mul_q       = r_q;
  assign mul_rst     = rst | w_timeout;
  assign rsp_valid   = (r_state == RESP);
  assign rsp_id      = r_id;
  assign rsp_err     = r_err;
  assign rsp_product = r_prod;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (w_gvalid) w_next = ISSUE;
      ISSUE: w_next = WAIT;
      WAIT:  if (mul_done || w_timeout) w_next = RESP;
      RESP:  if (rsp_ready) w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= 1'b0;
      r_timer <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_id    <= 1'b0;
      r_err   <= 1'b0;
      r_prod  <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        IDLE: begin
          if (w_gvalid) begin
            r_m  <= w_grant ? req1_m : req0_m;
            r_q  <= w_grant ? req1_q : req0_q;
            r_id <= w_grant;
          end
        end
        ISSUE: r_timer <= '0;
        WAIT: begin
          r_timer <= r_timer + 1'b1;
          if (mul_done) begin
            r_prod <= mul_product;
            r_err  <= 1'b0;
          end else if (w_timeout) begin
            r_prod <= '0;
            r_err  <= 1'b1;
          end
        end
        RESP: if (rsp_ready) r_ptr <= ~r_id;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter with a hand-driven multiplier.
module tb_booth_mul_arbiter;

  localparam int W  = 16;
  localparam int TO = 40;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0_valid, req1_valid;
  logic [W-1:0]   req0_m, req0_q, req1_m, req1_q;
  logic           req0_ready, req1_ready;
  logic           mul_start, mul_rst, mul_done;
  logic [W-1:0]   mul_m, mul_q;
  logic [2*W-1:0] mul_product;
  logic           rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [2*W-1:0] rsp_product;

  int checks   = 0;
  int failures = 0;
  int rcnt;
  bit bad;
  logic rs;

  booth_mul_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_m      (req0_m),
    .req0_q      (req0_q),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_m      (req1_m),
    .req1_q      (req1_q),
    .req1_ready  (req1_ready),
    .mul_start   (mul_start),
    .mul_m       (mul_m),
    .mul_q       (mul_q),
    .mul_rst     (mul_rst),
    .mul_done    (mul_done),
    .mul_product (mul_product),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_err     (rsp_err),
    .rsp_product (rsp_product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of the mul_start cycle; done lands dly cycles later
  task automatic finish_mul(input int dly, input logic [2*W-1:0] p,
                            output logic rst_at_done);
    repeat (dly) @(negedge clk);
    mul_done    = 1'b1;
    mul_product = p;
    #1;
    rst_at_done = mul_rst;
    @(negedge clk);
    mul_done    = 1'b0;
    mul_product = '0;
  endtask

  task automatic rsp_hs();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_m = '0; req0_q = '0; req1_m = '0; req1_q = '0;
    mul_done = 1'b0; mul_product = '0; rsp_ready = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_mul_rst", mul_rst, 1);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_mul_m", mul_m, 0);
    chk("rst_mul_q", mul_q, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_product", rsp_product, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_mul_rst", mul_rst, 0);
    chk("idle_no_ready", {req0_ready, req1_ready}, 0);

    // req0 3*2, done after 17 cycles
    req0_valid = 1'b1; req0_m = 16'd3; req0_q = 16'd2;
    #1;
    chk("t1_ready0", req0_ready, 1);
    chk("t1_ready1", req1_ready, 0);
    @(negedge clk);
    chk("t1_start", mul_start, 1);
    chk("t1_mul_m", mul_m, 16'd3);
    chk("t1_mul_q", mul_q, 16'd2);
    chk("t1_busy_ready", req0_ready, 0);
    req0_valid = 1'b0;
    finish_mul(17, 32'd6, rs);
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_id", rsp_id, 0);
    chk("t1_rsp_product", rsp_product, 32'd6);
    chk("t1_rsp_err", rsp_err, 0);
    rsp_hs();
    chk("t1_after_hs", rsp_valid, 0);

    // both valid from reset: grants alternate 0,1,0,1
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b1; req0_m = 16'd5;    req0_q = 16'd7;
    req1_valid = 1'b1; req1_m = 16'hFFFD; req1_q = 16'd5;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d_ready0", i), req0_ready, (i % 2) == 0);
      chk($sformatf("rr%0d_ready1", i), req1_ready, (i % 2) == 1);
      @(negedge clk);
      chk($sformatf("rr%0d_start", i), mul_start, 1);
      chk($sformatf("rr%0d_mul_m", i), mul_m,
          (i % 2) ? 16'hFFFD : 16'd5);
      chk($sformatf("rr%0d_issue_ready", i),
          {req0_ready, req1_ready}, 0);
      finish_mul(3, (i % 2) ? 32'hFFFF_FFF1 : 32'd35, rs);
      chk($sformatf("rr%0d_rsp_id", i), rsp_id, i % 2);
      chk($sformatf("rr%0d_rsp_product", i), rsp_product,
          (i % 2) ? 32'hFFFF_FFF1 : 32'd35);
      rsp_hs();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // mul_done while idle is ignored
    mul_done = 1'b1; mul_product = 32'h1234;
    @(negedge clk);
    mul_done = 1'b0; mul_product = '0;
    chk("idle_done_rsp", rsp_valid, 0);
    chk("idle_done_start", mul_start, 0);

    // done in the timeout cycle: no error, no mul_rst
    req0_valid = 1'b1; req0_m = 16'd2; req0_q = 16'd3;
    @(negedge clk);
    req0_valid = 1'b0;
    chk("coll_start", mul_start, 1);
    finish_mul(TO - 1, 32'd6, rs);
    chk("coll_mul_rst", rs, 0);
    chk("coll_rsp_valid", rsp_valid, 1);
    chk("coll_rsp_err", rsp_err, 0);
    chk("coll_rsp_product", rsp_product, 32'd6);
    rsp_hs();

    // timeout on req1 (pointer now favours 1)
    req1_valid = 1'b1; req1_m = 16'd9; req1_q = 16'd9;
    @(negedge clk);
    req1_valid = 1'b0;
    chk("to_start", mul_start, 1);
    rcnt = 0; bad = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      if (mul_rst === 1'b1) rcnt++;
      if (k < TO && rsp_valid !== 1'b0) bad = 1'b1;
    end
    chk("to_early_rsp", bad, 0);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rst_pulses", rcnt, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_product", rsp_product, 0);
    chk("to_rsp_id", rsp_id, 1);

    // stall response 5 cycles with both requesters waiting
    req0_valid = 1'b1; req1_valid = 1'b1;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_id !== 1'b1 ||
          rsp_product !== '0 || req0_ready !== 1'b0 ||
          req1_ready !== 1'b0)
        bad = 1'b1;
    end
    chk("stall_stable", bad, 0);
    rsp_hs();
    #1;
    chk("stall_next_ready0", req0_ready, 1);
    chk("stall_next_ready1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("stall_no_accept", mul_start, 0);

    // reset during WAIT discards the request
    req0_valid = 1'b1; req0_m = 16'd4; req0_q = 16'd4;
    @(negedge clk);
    req0_valid = 1'b0;
    chk("mid_start", mul_start, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_mul_rst", mul_rst, 1);
    chk("mid_mul_m", mul_m, 0);
    @(negedge clk);
    rst = 1'b0;
    mul_done = 1'b1; mul_product = 32'd16;
    @(negedge clk);
    mul_done = 1'b0; mul_product = '0;
    bad = 1'b0;
    repeat (3) begin
      if (rsp_valid !== 1'b0 || mul_start !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    chk("mid_no_rsp", bad, 0);
    req0_valid = 1'b1; req0_m = 16'd6; req0_q = 16'hFFFE;
    #1;
    chk("post_ready0", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    chk("post_start", mul_start, 1);
    chk("post_mul_q", mul_q, 16'hFFFE);
    finish_mul(5, 32'hFFFF_FFF4, rs);
    chk("post_rsp_valid", rsp_valid, 1);
    chk("post_rsp_id", rsp_id, 0);
    chk("post_rsp_err", rsp_err, 0);
    chk("post_rsp_product", rsp_product, 32'hFFFF_FFF4);
    rsp_hs();
    chk("post_idle", rsp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
